eth_tx_tstamp_req_fifo: RTL and testbench

ETH_TX_TSTAMP_REQ_FIFO -- requirements
Module: eth_tx_tstamp_req_fifo

---
 rtl/eth_tx_tstamp_req_fifo.sv | 151 +++++++++++++++
 tb/tb_eth_tx_tstamp_req_fifo.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_tx_tstamp_req_fifo.sv
// Ethernet TX timestamp-request tagger: passes packets through, issues an LFSR
// fingerprint per SOP and queues it in a show-ahead FIFO for later matching.
module eth_tx_tstamp_req_fifo #(
  parameter int          BITSPERSYMBOL  = 8,
  parameter int          SYMBOLSPERBEAT = 8,
  parameter int          EMPTY_WIDTH    = 3,
  parameter int          ERROR_WIDTH    = 6,
  parameter int          FP_WIDTH       = 8,
  parameter logic [15:0] LFSR_TAPS      = 16'h00B8,
  parameter logic [15:0] LFSR_SEED      = 16'h00A5,
  parameter int          FIFO_DEPTH     = 8,
  parameter int          STALL_ON_FULL  = 1,
  localparam int         DW             = BITSPERSYMBOL * SYMBOLSPERBEAT,
  localparam int         LW             = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   asi_pktin_sop,
  input  logic                   asi_pktin_eop,
  input  logic                   asi_pktin_valid,
  output logic                   asi_pktin_ready,
  input  logic [DW-1:0]          asi_pktin_data,
  input  logic [EMPTY_WIDTH-1:0] asi_pktin_empty,
  input  logic [ERROR_WIDTH-1:0] asi_pktin_error,
  output logic                   aso_pktout_sop,
  output logic                   aso_pktout_eop,
  output logic                   aso_pktout_valid,
  input  logic                   aso_pktout_ready,
  output logic [DW-1:0]          aso_pktout_data,
  output logic [EMPTY_WIDTH-1:0] aso_pktout_empty,
  output logic [ERROR_WIDTH-1:0] aso_pktout_error,
  output logic                   tstamp_req_valid,
  output logic [FP_WIDTH-1:0]    tstamp_req_fingerprint,
  output logic                   aso_fingerprint_valid,
  output logic [FP_WIDTH-1:0]    aso_fingerprint,
  input  logic                   aso_fingerprint_ready,
  output logic [LW-1:0]          fifo_level,
  output logic [15:0]            overflow_count
);

  localparam int                  PW   = $clog2(FIFO_DEPTH);
  localparam logic [FP_WIDTH-1:0] TAPS = LFSR_TAPS[FP_WIDTH-1:0];
  localparam logic [FP_WIDTH-1:0] SEED = LFSR_SEED[FP_WIDTH-1:0];

  if (FP_WIDTH < 4 || FP_WIDTH > 16) begin : g_bad_fp_width
    $error("FP_WIDTH must be in 4..16");
  end
  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 64 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of 2 in 2..64");
  end
  if (SEED == '0 || (LFSR_SEED >> FP_WIDTH) != 16'd0) begin : g_bad_seed
    $error("LFSR_SEED must be nonzero and fit in FP_WIDTH bits");
  end
  if (STALL_ON_FULL != 0 && STALL_ON_FULL != 1) begin : g_bad_stall
    $error("STALL_ON_FULL must be 0 or 1");
  end

  logic [FP_WIDTH-1:0] lfsr_q, lfsr_d;
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]       level_q, level_d;
  logic [15:0]         ovf_q, ovf_d;
  logic                in_packet_q, in_packet_d;
  logic [FP_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [FP_WIDTH-1:0] mem_d [FIFO_DEPTH];

  logic stall_en, fifo_full, fifo_empty, block, accept, sop_accept, push, pop, drop;

  assign stall_en   = (STALL_ON_FULL != 0);
  assign fifo_full  = (level_q == LW'(FIFO_DEPTH));
  assign fifo_empty = (level_q == '0);

  // Only packet starts are held back; a packet already underway always completes.
  assign block      = stall_en & fifo_full & ~in_packet_q;
  assign accept     = aso_pktout_valid & aso_pktout_ready;
  assign sop_accept = accept & aso_pktout_sop;
  assign pop        = ~fifo_empty & aso_fingerprint_ready;
  assign push       = sop_accept & (~fifo_full | pop);
  assign drop       = sop_accept & fifo_full & ~pop;

  assign aso_pktout_sop   = asi_pktin_sop;
  assign aso_pktout_eop   = asi_pktin_eop;
  assign aso_pktout_data  = asi_pktin_data;
  assign aso_pktout_empty = asi_pktin_empty;
  assign aso_pktout_error = asi_pktin_error;
  assign aso_pktout_valid = asi_pktin_valid & ~block;
  assign asi_pktin_ready  = aso_pktout_ready & ~block;

  assign tstamp_req_valid       = sop_accept;
  assign tstamp_req_fingerprint = lfsr_q;
  assign aso_fingerprint_valid  = ~fifo_empty;
  assign aso_fingerprint        = mem_q[rd_ptr_q];
  assign fifo_level             = level_q;
  assign overflow_count         = ovf_q;

  always_comb begin
    lfsr_d      = lfsr_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    ovf_d       = ovf_q;
    in_packet_d = in_packet_q;
    mem_d       = mem_q;
    if (sop_accept) begin
      lfsr_d = {lfsr_q[FP_WIDTH-2:0], ^(lfsr_q & TAPS)};
    end
    if (push) begin
      mem_d[wr_ptr_q] = lfsr_q;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (push && !pop) begin
      level_d = level_q + LW'(1);
    end else if (pop && !push) begin
      level_d = level_q - LW'(1);
    end
    if (drop && ovf_q != 16'hFFFF) begin
      ovf_d = ovf_q + 16'd1;
    end
    if (accept && aso_pktout_eop) begin
      in_packet_d = 1'b0;
    end else if (sop_accept) begin
      in_packet_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      lfsr_q      <= SEED;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      ovf_q       <= '0;
      in_packet_q <= 1'b0;
    end else begin
      lfsr_q      <= lfsr_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      ovf_q       <= ovf_d;
      in_packet_q <= in_packet_d;
    end
  end

  // Storage needs no reset: the pointers and level define which entries are live.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_eth_tx_tstamp_req_fifo.sv
// Bench for eth_tx_tstamp_req_fifo: directed scenarios plus randomized traffic
// checked against a queue-based model, on a stalling and a dropping instance.
module tb_eth_tx_tstamp_req_fifo;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_sop, in_eop, in_valid, out_ready, fp_ready;
  logic [63:0] in_data;
  logic [2:0]  in_empty;
  logic [5:0]  in_error;

  logic        s_in_ready, s_out_sop, s_out_eop, s_out_valid, s_treq_v, s_fpv;
  logic [63:0] s_out_data;
  logic [2:0]  s_out_empty;
  logic [5:0]  s_out_error;
  logic [7:0]  s_treq_fp, s_fp;
  logic [3:0]  s_level;
  logic [15:0] s_ovf;

  logic        d_in_ready, d_out_sop, d_out_eop, d_out_valid, d_treq_v, d_fpv;
  logic [63:0] d_out_data;
  logic [2:0]  d_out_empty;
  logic [5:0]  d_out_error;
  logic [7:0]  d_treq_fp, d_fp;
  logic [3:0]  d_level;
  logic [15:0] d_ovf;

  logic        sel;
  logic        o_in_ready, o_out_sop, o_out_eop, o_out_valid, o_treq_v, o_fpv;
  logic [63:0] o_out_data;
  logic [2:0]  o_out_empty;
  logic [5:0]  o_out_error;
  logic [7:0]  o_treq_fp, o_fp;
  logic [3:0]  o_level;
  logic [15:0] o_ovf;

  int tests_run    = 0;
  int tests_failed = 0;
  logic [7:0] seq [0:31];

  always #5 clock = ~clock;

  eth_tx_tstamp_req_fifo #(.STALL_ON_FULL(1)) dut_stall (
    .clock(clock), .reset(reset),
    .asi_pktin_sop(in_sop), .asi_pktin_eop(in_eop), .asi_pktin_valid(in_valid),
    .asi_pktin_ready(s_in_ready), .asi_pktin_data(in_data), .asi_pktin_empty(in_empty),
    .asi_pktin_error(in_error),
    .aso_pktout_sop(s_out_sop), .aso_pktout_eop(s_out_eop), .aso_pktout_valid(s_out_valid),
    .aso_pktout_ready(out_ready), .aso_pktout_data(s_out_data), .aso_pktout_empty(s_out_empty),
    .aso_pktout_error(s_out_error),
    .tstamp_req_valid(s_treq_v), .tstamp_req_fingerprint(s_treq_fp),
    .aso_fingerprint_valid(s_fpv), .aso_fingerprint(s_fp), .aso_fingerprint_ready(fp_ready),
    .fifo_level(s_level), .overflow_count(s_ovf)
  );

  eth_tx_tstamp_req_fifo #(.STALL_ON_FULL(0)) dut_drop (
    .clock(clock), .reset(reset),
    .asi_pktin_sop(in_sop), .asi_pktin_eop(in_eop), .asi_pktin_valid(in_valid),
    .asi_pktin_ready(d_in_ready), .asi_pktin_data(in_data), .asi_pktin_empty(in_empty),
    .asi_pktin_error(in_error),
    .aso_pktout_sop(d_out_sop), .aso_pktout_eop(d_out_eop), .aso_pktout_valid(d_out_valid),
    .aso_pktout_ready(out_ready), .aso_pktout_data(d_out_data), .aso_pktout_empty(d_out_empty),
    .aso_pktout_error(d_out_error),
    .tstamp_req_valid(d_treq_v), .tstamp_req_fingerprint(d_treq_fp),
    .aso_fingerprint_valid(d_fpv), .aso_fingerprint(d_fp), .aso_fingerprint_ready(fp_ready),
    .fifo_level(d_level), .overflow_count(d_ovf)
  );

  assign o_in_ready  = sel ? d_in_ready  : s_in_ready;
  assign o_out_sop   = sel ? d_out_sop   : s_out_sop;
  assign o_out_eop   = sel ? d_out_eop   : s_out_eop;
  assign o_out_valid = sel ? d_out_valid : s_out_valid;
  assign o_out_data  = sel ? d_out_data  : s_out_data;
  assign o_out_empty = sel ? d_out_empty : s_out_empty;
  assign o_out_error = sel ? d_out_error : s_out_error;
  assign o_treq_v    = sel ? d_treq_v    : s_treq_v;
  assign o_treq_fp   = sel ? d_treq_fp   : s_treq_fp;
  assign o_fpv       = sel ? d_fpv       : s_fpv;
  assign o_fp        = sel ? d_fp        : s_fp;
  assign o_level     = sel ? d_level     : s_level;
  assign o_ovf       = sel ? d_ovf       : s_ovf;

  function automatic logic [7:0] next_fp(input logic [7:0] x);
    return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
  endfunction

  task automatic idle_inputs();
    in_sop = 0; in_eop = 0; in_valid = 0; in_data = '0; in_empty = '0; in_error = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic send_beat(input logic s, input logic e, output logic ok, output int waits,
                           output logic tv, output logic [7:0] tf);
    ok = 0; waits = 0; tv = 0; tf = '0;
    in_sop = s; in_eop = e; in_valid = 1;
    in_data = {$urandom, $urandom}; in_empty = 3'($urandom); in_error = 6'($urandom);
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clock);
      if (o_in_ready) begin
        ok = 1; tv = o_treq_v; tf = o_treq_fp;
      end else begin
        waits++;
      end
      @(posedge clock); #1;
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    sel = 0; idle_inputs(); out_ready = 1; fp_ready = 0;
    do_reset();
    @(negedge clock);
    tests_run++;
    if (o_fpv !== 1'b0 || o_level !== 4'd0 || o_ovf !== 16'd0 || o_treq_v !== 1'b0 ||
        o_treq_fp !== 8'hA5) begin
      tests_failed++;
      $display("[TB] FAIL reset_state: fpv=%b level=%0d ovf=%0d treq_v=%b fp=%h, need 0 0 0 0 a5",
               o_fpv, o_level, o_ovf, o_treq_v, o_treq_fp);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_basic();
    logic ok, tv; int w; logic [7:0] tf;
    logic [7:0] exp_fp [3];
    exp_fp[0] = 8'hA5; exp_fp[1] = 8'h4A; exp_fp[2] = 8'h95;
    sel = 0; out_ready = 1; fp_ready = 1;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      send_beat(1, 1, ok, w, tv, tf);
      tests_run++;
      if (ok !== 1'b1 || tv !== 1'b1 || tf !== exp_fp[i]) begin
        tests_failed++;
        $display("[TB] FAIL basic_treq%0d: ok=%b v=%b fp=%h, need 1 1 %h", i, ok, tv, tf, exp_fp[i]);
      end
      @(negedge clock);
      tests_run++;
      if (o_fpv !== 1'b1 || o_fp !== exp_fp[i]) begin
        tests_failed++;
        $display("[TB] FAIL basic_fifo_out%0d: v=%b fp=%h, need 1 %h", i, o_fpv, o_fp, exp_fp[i]);
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_stall_full();
    logic ok, tv; int w; logic [7:0] tf;
    sel = 0; out_ready = 1; fp_ready = 0;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      send_beat(1, 1, ok, w, tv, tf);
      tests_run++;
      if (ok !== 1'b1 || tf !== seq[i]) begin
        tests_failed++;
        $display("[TB] FAIL stall_fill%0d: ok=%b fp=%h, need 1 %h", i, ok, tf, seq[i]);
      end
    end
    in_sop = 1; in_eop = 1; in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      tests_run++;
      if (o_in_ready !== 1'b0 || o_level !== 4'd8) begin
        tests_failed++;
        $display("[TB] FAIL stall_blocked%0d: ready=%b level=%0d, need 0 8", i, o_in_ready, o_level);
      end
      @(posedge clock); #1;
    end
    fp_ready = 1;
    @(posedge clock); #1;
    fp_ready = 0;
    @(negedge clock);
    tests_run++;
    if (o_in_ready !== 1'b1 || o_treq_v !== 1'b1 || o_treq_fp !== seq[8]) begin
      tests_failed++;
      $display("[TB] FAIL stall_ninth: ready=%b v=%b fp=%h, need 1 1 %h",
               o_in_ready, o_treq_v, o_treq_fp, seq[8]);
    end
    @(posedge clock); #1;
    idle_inputs();
    @(negedge clock);
    tests_run++;
    if (o_level !== 4'd8 || o_fp !== seq[1]) begin
      tests_failed++;
      $display("[TB] FAIL stall_after: level=%0d head=%h, need 8 %h", o_level, o_fp, seq[1]);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_drop();
    logic ok, tv; int w; logic [7:0] tf;
    sel = 1; out_ready = 1; fp_ready = 0;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      send_beat(1, 1, ok, w, tv, tf);
      tests_run++;
      if (ok !== 1'b1 || w !== 0 || tf !== seq[i]) begin
        tests_failed++;
        $display("[TB] FAIL drop_send%0d: ok=%b waits=%0d fp=%h, need 1 0 %h", i, ok, w, tf, seq[i]);
      end
    end
    @(negedge clock);
    tests_run++;
    if (o_ovf !== 16'd1 || o_level !== 4'd8) begin
      tests_failed++;
      $display("[TB] FAIL drop_count: ovf=%0d level=%0d, need 1 8", o_ovf, o_level);
    end
    @(posedge clock); #1;
    fp_ready = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      tests_run++;
      if (o_fpv !== 1'b1 || o_fp !== seq[i]) begin
        tests_failed++;
        $display("[TB] FAIL drop_drain%0d: v=%b fp=%h, need 1 %h", i, o_fpv, o_fp, seq[i]);
      end
      @(posedge clock); #1;
    end
    fp_ready = 0;
    @(negedge clock);
    tests_run++;
    if (o_level !== 4'd0 || o_treq_fp !== seq[9]) begin
      tests_failed++;
      $display("[TB] FAIL drop_next_fp: level=%0d fp=%h, need 0 %h", o_level, o_treq_fp, seq[9]);
    end
    @(posedge clock); #1;
    sel = 0;
  endtask

  task automatic test_fill_mid_packet();
    logic ok, tv; int w; logic [7:0] tf;
    sel = 0; out_ready = 1; fp_ready = 0;
    do_reset();
    for (int i = 0; i < 7; i++) send_beat(1, 1, ok, w, tv, tf);
    send_beat(1, 0, ok, w, tv, tf);
    tests_run++;
    if (ok !== 1'b1 || tf !== seq[7]) begin
      tests_failed++;
      $display("[TB] FAIL fill_sop: ok=%b fp=%h, need 1 %h", ok, tf, seq[7]);
    end
    for (int b = 2; b <= 4; b++) begin
      send_beat(0, (b == 4), ok, w, tv, tf);
      tests_run++;
      if (ok !== 1'b1 || w !== 0 || tv !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL fill_beat%0d: ok=%b waits=%0d treq=%b, need 1 0 0", b, ok, w, tv);
      end
    end
    in_sop = 1; in_eop = 1; in_valid = 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      tests_run++;
      if (o_in_ready !== 1'b0 || o_out_valid !== 1'b0 || o_level !== 4'd8) begin
        tests_failed++;
        $display("[TB] FAIL fill_next_sop%0d: ready=%b valid=%b level=%0d, need 0 0 8",
                 i, o_in_ready, o_out_valid, o_level);
      end
      @(posedge clock); #1;
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_packet();
    logic ok, tv; int w; logic [7:0] tf;
    sel = 0; out_ready = 1; fp_ready = 0;
    do_reset();
    send_beat(1, 1, ok, w, tv, tf);
    send_beat(1, 1, ok, w, tv, tf);
    send_beat(1, 0, ok, w, tv, tf);
    @(negedge clock);
    tests_run++;
    if (o_level !== 4'd3) begin
      tests_failed++;
      $display("[TB] FAIL rstmid_level_before: level=%0d, need 3", o_level);
    end
    @(posedge clock); #1;
    in_valid = 1; in_sop = 0; in_eop = 0; reset = 1;
    @(posedge clock); #1;
    reset = 0; idle_inputs();
    @(negedge clock);
    tests_run++;
    if (o_level !== 4'd0 || o_treq_fp !== 8'hA5 || o_fpv !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL rstmid_state: level=%0d fp=%h fpv=%b, need 0 a5 0", o_level, o_treq_fp, o_fpv);
    end
    @(posedge clock); #1;
    send_beat(0, 1, ok, w, tv, tf);
    tests_run++;
    if (ok !== 1'b1 || tv !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL rstmid_nonsop: ok=%b treq=%b, need 1 0", ok, tv);
    end
    send_beat(1, 1, ok, w, tv, tf);
    tests_run++;
    if (ok !== 1'b1 || tv !== 1'b1 || tf !== 8'hA5) begin
      tests_failed++;
      $display("[TB] FAIL rstmid_sop: ok=%b v=%b fp=%h, need 1 1 a5", ok, tv, tf);
    end
    @(negedge clock);
    tests_run++;
    if (o_fpv !== 1'b1 || o_fp !== 8'hA5) begin
      tests_failed++;
      $display("[TB] FAIL rstmid_fifo: v=%b fp=%h, need 1 a5", o_fpv, o_fp);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_random(input logic which, input int cycles);
    logic [7:0] q [$];
    logic [7:0] m_lfsr;
    logic       m_inpkt, full, blk, e_valid, e_ready, acc, sopacc, pop;
    int         m_ovf;
    sel = which; idle_inputs(); out_ready = 1; fp_ready = 0;
    do_reset();
    q.delete(); m_lfsr = 8'hA5; m_inpkt = 0; m_ovf = 0;
    for (int c = 0; c < cycles; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_sop    = ($urandom_range(0, 2) == 0);
      in_eop    = ($urandom_range(0, 2) == 0);
      in_data   = {$urandom, $urandom};
      in_empty  = 3'($urandom);
      in_error  = 6'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      fp_ready  = ($urandom_range(0, 9) < 4);
      @(negedge clock);
      full    = (q.size() == 8);
      blk     = !which && full && !m_inpkt;
      e_valid = in_valid && !blk;
      e_ready = out_ready && !blk;
      acc     = e_valid && out_ready;
      sopacc  = acc && in_sop;
      tests_run++;
      if (o_in_ready !== e_ready || o_out_valid !== e_valid) begin
        tests_failed++;
        $display("[TB] FAIL rand%0d_handshake c%0d: ready=%b valid=%b, need %b %b",
                 which, c, o_in_ready, o_out_valid, e_ready, e_valid);
      end
      tests_run++;
      if (o_out_sop !== in_sop || o_out_eop !== in_eop || o_out_data !== in_data ||
          o_out_empty !== in_empty || o_out_error !== in_error) begin
        tests_failed++;
        $display("[TB] FAIL rand%0d_passthru c%0d: data=%h, need %h", which, c, o_out_data, in_data);
      end
      tests_run++;
      if (o_treq_v !== sopacc || o_treq_fp !== m_lfsr) begin
        tests_failed++;
        $display("[TB] FAIL rand%0d_treq c%0d: v=%b fp=%h, need %b %h",
                 which, c, o_treq_v, o_treq_fp, sopacc, m_lfsr);
      end
      tests_run++;
      if (o_fpv !== (q.size() != 0) || (q.size() != 0 && o_fp !== q[0]) ||
          o_level !== 4'(q.size()) || o_ovf !== 16'(m_ovf)) begin
        tests_failed++;
        $display("[TB] FAIL rand%0d_fifo c%0d: fpv=%b fp=%h level=%0d ovf=%0d, need level %0d ovf %0d",
                 which, c, o_fpv, o_fp, o_level, o_ovf, q.size(), m_ovf);
      end
      pop = (q.size() != 0) && fp_ready;
      if (pop) void'(q.pop_front());
      if (sopacc) begin
        if (q.size() < 8) q.push_back(m_lfsr);
        else if (m_ovf < 65535) m_ovf++;
        m_lfsr = next_fp(m_lfsr);
      end
      if (acc && in_eop) m_inpkt = 0;
      else if (sopacc) m_inpkt = 1;
      @(posedge clock); #1;
    end
    idle_inputs(); fp_ready = 0;
    sel = 0;
  endtask

  initial begin
    seq[0] = 8'hA5;
    for (int i = 1; i < 32; i++) seq[i] = next_fp(seq[i-1]);
    reset = 1; sel = 0; out_ready = 1; fp_ready = 0;
    idle_inputs();
    test_reset();
    test_basic();
    test_stall_full();
    test_drop();
    test_fill_mid_packet();
    test_reset_mid_packet();
    test_random(1'b0, 1500);
    test_random(1'b1, 1500);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
